// File: rtl/au_add_arb_pkg.sv
// AU_pkg: shared sizing helpers and requester-count limits for the arbitrated adder.
package AU_pkg;
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/au_add.sv
// AU_add: carry-in-free adder; ARCH 0 ripple, 1 Kogge-Stone, 2 Sklansky prefix network.
module AU_add #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o
);
    logic [WIDTH-1:0] x, g, p, gn, pn;
    int j;

    // After the network, g[i] is the group generate of bits [i:0], i.e. the carry into bit i+1.
    always_comb begin
        x  = a_i ^ b_i;
        g  = a_i & b_i;
        p  = x;
        gn = g;
        pn = p;
        j  = 0;
        if (ARCH == 0) begin
            for (int i = 1; i < WIDTH; i++) g[i] = g[i] | (p[i] & g[i-1]);
        end else begin
            for (int l = 0; (1 << l) < WIDTH; l++) begin
                gn = g;
                pn = p;
                for (int i = 0; i < WIDTH; i++) begin
                    j = (ARCH == 1) ? i - (1 << l) : (((i >> l) & 1) != 0) ? ((i >> l) << l) - 1 : -1;
                    if (j >= 0) begin
                        gn[i] = g[i] | (p[i] & g[j]);
                        pn[i] = p[i] & p[j];
                    end
                end
                g = gn;
                p = pn;
            end
        end
        s_o = x ^ (g << 1);
    end
endmodule

// File: rtl/au_add_arb_rr_arb.sv
// AU_rr_arb: round-robin one-hot grant searching upward from ptr, ptr advancing past each winner.
module AU_rr_arb import AU_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NREQ-1:0] valid_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gid_o
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic hit;
    int idx;

    // Scanning from the far end down lets the requester closest to ptr win last.
    always_comb begin
        gid_o = '0;
        hit   = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (valid_i[idx]) begin
                gid_o = IDW'(idx);
                hit   = 1'b1;
            end
        end
        gnt_o = (en_i && hit) ? (NREQ'(1) << gid_o) : '0;
        ptr_d = (gid_o == IDW'(NREQ - 1)) ? '0 : gid_o + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else if (en_i && hit) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/au_add_arb.sv
// au_add_arb: NREQ requesters share one adder through a round-robin arbiter and a one-deep result slot.
// Define AU_ADD_ARB_COUT_EN to widen the adder by one bit and expose the registered carry on res_co.
module au_add_arb import AU_pkg::*; #(
    parameter  int WIDTH = 8,
    parameter  int ARCH  = 0,
    parameter  int NREQ  = 4,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_s,
    output logic [IDW-1:0]        res_id
`ifdef AU_ADD_ARB_COUT_EN
    ,
    output logic                  res_co
`endif
);
`ifdef AU_ADD_ARB_COUT_EN
    localparam int AW = WIDTH + 1;
`else
    localparam int AW = WIDTH;
`endif

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("au_add_arb: NREQ out of range");
    end

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gid;
    logic [WIDTH-1:0] op_a, op_b;
    logic [AW-1:0]    sum;
    logic             free, take, res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_s_q;
    logic [IDW-1:0]   res_id_q;

    assign free = !res_valid_q || res_ready;

    AU_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (free && rst_n),
        .valid_i (req_valid),
        .gnt_o   (gnt),
        .gid_o   (gid)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a = op_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
            op_b = op_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
        take        = |gnt;
        res_valid_d = take || (res_valid_q && !res_ready);
    end

    AU_add #(.WIDTH(AW), .ARCH(ARCH)) u_add (
        .a_i (AW'(op_a)),
        .b_i (AW'(op_b)),
        .s_o (sum)
    );

`ifdef AU_ADD_ARB_COUT_EN
    logic res_co_q;
    assign res_co = res_co_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_id_q    <= '0;
`ifdef AU_ADD_ARB_COUT_EN
            res_co_q    <= 1'b0;
`endif
        end else begin
            res_valid_q <= res_valid_d;
            if (take) begin
                res_s_q  <= sum[WIDTH-1:0];
                res_id_q <= gid;
`ifdef AU_ADD_ARB_COUT_EN
                res_co_q <= sum[WIDTH];
`endif
            end
        end
    end

    assign req_ready = gnt;
    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_id    = res_id_q;
endmodule
